lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Sequences every load/store from the memory stage onto the single-ported data-memory bus.
- Takes the effective address produced by the address-generation logic, plus op size, signedness and store data.
- Drives a req/gnt/rvalid handshake, generates byte enables and lane-replicated write data, and sign/zero-extends load data.
- Stalls the pipeline until the access completes, faults on misalignment, and enforces a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before the access is aborted with a timeout fault. Legal range is 2..255.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  memory op present in the memory stage
- req_store_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend load result (LBU/LHU)
- req_addr_i  in  32  effective address (imm + rs1)
- req_wdata_i  in  32  store data (rs2)
- stall_o  out  1  freeze pipeline
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result, valid when done_o=1
- fault_o  out  1  one-cycle fault pulse
- fault_cause_o  out  2  01 misaligned/illegal size, 10 timeout; 00 otherwise
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid / write acknowledged
- mem_rdata_i  in  32  read word

Behaviour:
- Reset (async): state=IDLE, timeout counter=0, all registered fields 0. All outputs 0; mem_req_o drops immediately, including mid-access. Any later mem_rvalid_i is ignored.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=00, or size=11.
- State IDLE:
  - On req_valid_i & aligned: capture store/size/unsigned/addr/wdata; go to REQ.
  - On req_valid_i & misaligned: fault_o=1, fault_cause_o=01, stall_o=0; stay in IDLE; no bus activity.
  - stall_o=req_valid_i & aligned (combinational).
- State REQ: mem_req_o=1 with stable addr/we/be/wdata until mem_gnt_i.
  - gnt & rvalid in the same cycle: go to DONE.
  - gnt alone: go to WAIT.
- State WAIT: mem_req_o=0; on mem_rvalid_i go to DONE; load data is captured that cycle.
- State DONE:
  - done_o=1, stall_o=0, rdata_o valid (0 for stores).
  - Always returns to IDLE. req_valid_i seen in DONE is the same completing op and is ignored.
- stall_o=1 in REQ and WAIT.
- Timeout:
  - The counter clears on entering REQ and increments each REQ/WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without completion, the next state is DONE with fault_o=1, fault_cause_o=10, done_o=1, rdata_o=0.
  - mem_req_o drops. A late rvalid is ignored.
- Latency:
  - Best case (gnt and rvalid in the cycle after acceptance): done_o 2 cycles after the accept edge.
  - Typical (gnt, then rvalid next cycle): 3 cycles.
- Byte enables, with o=addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
  - mem_we_o=req_store captured.
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Load extraction:
  - byte lane = rdata[8*o+7:8*o]; half lane = rdata[16*o[1]+15:16*o[1]].
  - Lane is sign-extended unless unsigned=1.
- rdata_o is registered and holds its value until the next DONE.
- rvalid arriving in IDLE or REQ without gnt is ignored.

Test Plan:
- Load word, addr 0x1000_0004, gnt in 1st REQ cycle, rvalid one cycle later with 0xDEAD_BEEF -> mem_be_o=1111, mem_addr_o=0x1000_0004, done_o and rdata_o=0xDEAD_BEEF 3 cycles after accept; stall_o high in REQ and WAIT, low in DONE.
- LB at addr 0x...03, rdata 0x80FF_FFFF -> be=1000, rdata_o=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at addr 0x...02, wdata 0x1234_ABCD, gnt delayed 3 cycles -> mem_req_o held 4 cycles with be=1100, wdata=0xABCD_ABCD, we=1; done_o after rvalid ack.
- LW at addr 0x...02 -> fault_o=1, fault_cause_o=01 in the same cycle, no mem_req_o, stall_o=0. Repeat with size=11 -> same response.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req_o high 4 cycles, then done_o=1, fault_cause_o=10, mem_req_o=0. Rvalid injected afterwards -> no done_o.
- Assert rst while in WAIT -> all outputs 0 asynchronously, state IDLE. Subsequent rvalid is ignored; next load completes normally.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store unit bus sequencer: moves one memory-stage access at a time over a
// req/gnt/rvalid data bus, with lane steering, load extension, alignment and timeout faults.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;

    logic        misaligned;
    logic        idle_valid;
    logic        complete;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] load_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be_new    = 4'b0001 << req_addr_i[1:0];
                wdata_new = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr_i[0];
                be_new     = 4'b0011 << req_addr_i[1:0];
                wdata_new  = {2{req_wdata_i[15:0]}};
            end
            2'b10:   misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane selection uses the captured offset; the bus word itself is never registered.
    always_comb begin
        byte_lane = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_lane = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign complete = mem_rvalid_i & ((state_q == S_REQ & mem_gnt_i) | state_q == S_WAIT);

    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !misaligned) begin
                    store_d = req_store_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if (complete) begin
                    rdata_d = store_q ? 32'h0 : load_ext;
                    to_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (state_q == S_REQ && mem_gnt_i) state_d = S_WAIT;
                end
            end
            S_DONE: begin
                to_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // NOTE: the IDLE-cycle responses are combinational, so they are masked by rst to keep outputs quiet in reset.
    assign idle_valid = (state_q == S_IDLE) & req_valid_i & ~rst;

    assign stall_o     = (state_q == S_REQ) | (state_q == S_WAIT) | (idle_valid & ~misaligned);
    assign done_o      = (state_q == S_DONE);
    assign rdata_o     = rdata_q;
    assign fault_o     = (done_o & to_q) | (idle_valid & misaligned);
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = mem_req_o & store_q;
    assign mem_be_o    = mem_req_o ? be_q : 4'h0;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q;

    always_comb begin
        fault_cause_o = 2'b00;
        if (done_o && to_q)                 fault_cause_o = 2'b10;
        else if (idle_valid && misaligned)  fault_cause_o = 2'b01;
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: a transaction-level model checked every cycle,
// plus literal expectations per access and a short-timeout instance.
module tb_lsu_controller;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid4 = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        stall, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  cause;
    logic [3:0]  mem_be;
    logic        stall4, done4, fault4, mem_req4, mem_we4;
    logic [31:0] rdata4, mem_addr4, mem_wdata4;
    logic [1:0]  cause4;
    logic [3:0]  mem_be4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_store_i(req_store), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .done_o(done), .rdata_o(rdata), .fault_o(fault), .fault_cause_o(cause),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu_controller #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid4), .req_store_i(req_store), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall4), .done_o(done4), .rdata_o(rdata4), .fault_o(fault4), .fault_cause_o(cause4),
        .mem_req_o(mem_req4), .mem_we_o(mem_we4), .mem_be_o(mem_be4), .mem_addr_o(mem_addr4),
        .mem_wdata_o(mem_wdata4), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
        if (sz == 2'b00) return 4'(1 << o);
        if (sz == 2'b01) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'b00) return {4{w[7:0]}};
        if (sz == 2'b01) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] sz, input logic un,
                                           input logic [1:0] o, input logic [31:0] d);
        logic [31:0] mask, lane;
        int sh;
        if (sz == 2'b10) return d;
        mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh   = (sz == 2'b00) ? 8 * int'(o) : 16 * int'(o[1]);
        lane = (d >> sh) & mask;
        if (!un && (lane & ((mask >> 1) + 32'h1)) != 0) lane = lane | ~mask;
        return lane;
    endfunction

    // Transaction model: an accepted op is busy until it completes or runs out of cycles.
    logic        m_busy = 1'b0, m_gr = 1'b0, m_done = 1'b0, m_to = 1'b0, m_fin;
    int          m_cnt = 0;
    logic        m_st = 1'b0, m_un = 1'b0;
    logic [1:0]  m_sz = 2'b00;
    logic [31:0] m_addr = 32'h0, m_wd = 32'h0, m_rdata = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_gr = 1'b0; m_done = 1'b0; m_to = 1'b0; m_cnt = 0;
            m_st = 1'b0; m_un = 1'b0; m_sz = 2'b00; m_addr = 32'h0; m_wd = 32'h0; m_rdata = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_fin = mem_rvalid && (m_gr || mem_gnt);
            if (m_fin) begin
                m_busy = 1'b0; m_done = 1'b1; m_to = 1'b0;
                m_rdata = m_st ? 32'h0 : extend(m_sz, m_un, m_addr[1:0], mem_rdata);
            end else if (m_cnt == TO - 1) begin
                m_busy = 1'b0; m_done = 1'b1; m_to = 1'b1; m_rdata = 32'h0;
            end else begin
                m_cnt++;
                if (mem_gnt) m_gr = 1'b1;
            end
        end else if (req_valid && !is_mis(req_size, req_addr)) begin
            m_st = req_store; m_sz = req_size; m_un = req_unsigned;
            m_addr = req_addr; m_wd = req_wdata;
            m_busy = 1'b1; m_gr = 1'b0; m_cnt = 0;
        end
    end

    logic e_idle, e_mis, e_acc;
    always @(negedge clk) begin
        e_idle = !m_busy && !m_done;
        e_mis  = e_idle && req_valid && !rst && is_mis(req_size, req_addr);
        e_acc  = e_idle && req_valid && !rst && !is_mis(req_size, req_addr);
        check("cyc stall", 32'(stall), 32'(m_busy || e_acc));
        check("cyc done", 32'(done), 32'(m_done));
        check("cyc fault", 32'(fault), 32'((m_done && m_to) || e_mis));
        check("cyc cause", 32'(cause), (m_done && m_to) ? 32'd2 : (e_mis ? 32'd1 : 32'd0));
        check("cyc mem_req", 32'(mem_req), 32'(m_busy && !m_gr));
        check("cyc rdata", rdata, m_rdata);
        if (m_busy && !m_gr) begin
            check("cyc we", 32'(mem_we), 32'(m_st));
            check("cyc be", 32'(mem_be), 32'(lane_be(m_sz, m_addr[1:0])));
            check("cyc addr", mem_addr, {m_addr[31:2], 2'b00});
            check("cyc wdata", mem_wdata, lane_wd(m_sz, m_wd));
        end
    end

    // Caller is just past a rising edge with the DUT idle; gnt comes gd REQ cycles late, rvalid rd cycles after gnt.
    task automatic run_op(input string nm, input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int gd, input int rd,
                          input logic [31:0] bus_rd, input int exp_lat, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_req);
        int t = 0, lat = 0, rq = 0;
        logic [31:0] got_rd = 32'h0;
        req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (lat == 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
            mem_gnt    = (t == 1 + gd);
            mem_rvalid = (t == 1 + gd + rd);
            mem_rdata  = mem_rvalid ? bus_rd : 32'h5A5A_5A5A;
            @(negedge clk);
            if (t == 1) begin
                check({nm, " be"}, 32'(mem_be), 32'(exp_be));
                check({nm, " wdata"}, mem_wdata, exp_wd);
            end
            if (mem_req) rq++;
            if (done) begin
                lat = t;
                got_rd = rdata;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " rdata"}, got_rd, exp_rd);
        check({nm, " req cycles"}, 32'(rq), 32'(exp_req));
    endtask

    task automatic mis_op(input string nm, input logic [1:0] sz, input logic [31:0] a);
        req_store = 1'b0; req_size = sz; req_addr = a; req_valid = 1'b1;
        @(negedge clk);
        check({nm, " fault"}, 32'(fault), 32'd1);
        check({nm, " cause"}, 32'(cause), 32'd1);
        check({nm, " stall"}, 32'(stall), 32'd0);
        check({nm, " mem_req"}, 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, lat, lat4, rq, rq4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("LW", 1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF,
               3, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1);
        run_op("LB", 1'b0, 2'b00, 1'b0, 32'h2000_0003, 32'h0, 0, 0, 32'h80FF_FFFF,
               2, 32'hFFFF_FF80, 4'b1000, 32'h0, 1);
        run_op("LBU", 1'b0, 2'b00, 1'b1, 32'h2000_0003, 32'h0, 0, 0, 32'h80FF_FFFF,
               2, 32'h0000_0080, 4'b1000, 32'h0, 1);
        run_op("SH", 1'b1, 2'b01, 1'b0, 32'h3000_0002, 32'h1234_ABCD, 3, 1, 32'h0,
               6, 32'h0, 4'b1100, 32'hABCD_ABCD, 4);
        run_op("LH", 1'b0, 2'b01, 1'b0, 32'h4000_0002, 32'h0, 1, 2, 32'h8001_1234,
               5, 32'hFFFF_8001, 4'b1100, 32'h0, 2);
        run_op("LHU", 1'b0, 2'b01, 1'b1, 32'h4000_0000, 32'h0, 0, 1, 32'h8001_1234,
               3, 32'h0000_1234, 4'b0011, 32'h0, 1);
        run_op("SB", 1'b1, 2'b00, 1'b0, 32'h5000_0001, 32'hAAAA_BB55, 0, 0, 32'h0,
               2, 32'h0, 4'b0010, 32'h5555_5555, 1);
        run_op("SW", 1'b1, 2'b10, 1'b0, 32'h6000_0008, 32'hCAFE_F00D, 1, 0, 32'h0,
               3, 32'h0, 4'b1111, 32'hCAFE_F00D, 2);

        mis_op("LW mis", 2'b10, 32'h1000_0002);
        mis_op("size11", 2'b11, 32'h1000_0000);
        mis_op("LH mis", 2'b01, 32'h1000_0001);

        // Bus never grants: both instances time out, then a stray rvalid must be ignored.
        req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h8000_0000;
        req_valid = 1'b1; req_valid4 = 1'b1;
        t = 0; lat = 0; lat4 = 0; rq = 0; rq4 = 0;
        while (lat == 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (lat4 != 0) req_valid4 = 1'b0;
            @(negedge clk);
            if (mem_req) rq++;
            if (mem_req4) rq4++;
            if (done4 && lat4 == 0) begin
                lat4 = t;
                check("TO4 fault", 32'(fault4), 32'd1);
                check("TO4 cause", 32'(cause4), 32'd2);
                check("TO4 mem_req", 32'(mem_req4), 32'd0);
                check("TO4 rdata", rdata4, 32'h0);
            end
            if (done) lat = t;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid4 = 1'b0;
        check("TO latency", 32'(lat), 32'd17);
        check("TO req cycles", 32'(rq), 32'd16);
        check("TO4 latency", 32'(lat4), 32'd5);
        check("TO4 req cycles", 32'(rq4), 32'd4);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("late rvalid done", 32'(done), 32'd0);
        check("late rvalid done4", 32'(done4), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        // Reset while waiting for read data.
        run_op("LW pre", 1'b0, 2'b10, 1'b0, 32'h0900_0000, 32'h0, 0, 0, 32'h0BAD_F00D,
               2, 32'h0BAD_F00D, 4'b1111, 32'h0, 1);
        req_size = 2'b10; req_addr = 32'h0A00_0000; req_valid = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("WAIT stall", 32'(stall), 32'd1);
        #1;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("async rst stall", 32'(stall), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst mem_req", 32'(mem_req), 32'd0);
        check("async rst fault", 32'(fault), 32'd0);
        check("async rst rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        check("post-rst rvalid done", 32'(done), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        run_op("LW post", 1'b0, 2'b10, 1'b0, 32'h7000_0000, 32'h0, 0, 1, 32'h1234_5678,
               3, 32'h1234_5678, 4'b1111, 32'h0, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
